mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high.
REQ-003 SHALL have: instr  in  32  current instruction register contents (opcode [6:0], funct3 [14:12], funct7b5 [30]).
REQ-004 SHALL have: mem_ready  in  1  memory handshake, access completes in the cycle it is high.
REQ-005 SHALL have: branch_taken  in  1  ALU branch result, sampled in BRANCH only.
REQ-006 SHALL have: mem_req  out  1  memory access request.
REQ-007 SHALL have: mem_we  out  1  write qualifier for mem_req.
REQ-008 SHALL have: addr_sel  out  1  memory address source (0 PC, 1 ALU-out register).
REQ-009 SHALL have: ir_write, pc_write, target_write, reg_write  out  1 each  register enables.
REQ-010 SHALL have: pc_src  out  1  next PC source (0 ALU result, 1 target register).
REQ-011 SHALL have: alu_a_sel  out  2  (00 rs1, 01 PC, 10 old_PC).
REQ-012 SHALL have: alu_b_sel  out  2  (00 rs2, 01 imm, 10 constant 4).
REQ-013 SHALL have: alu_func  out  4  ALU operation code.
REQ-014 SHALL have: result_src  out  2  write-back source (00 ALU-out, 01 mem data, 10 PC).
REQ-015 SHALL have: halted  out  1  illegal instruction seen; state  out  4  debug; retired  out  32  instruction count.

Function
REQ-016 SHALL be a Moore FSM; outputs depend on state and instr only; outputs not listed for a state are 0.
REQ-017 SHALL use ALU codes ADD 0000, ADDI 0001, LOAD 0010, STORE 0011, LUI 0100, JUMP 0101, OR 0110, AND 0111, BRANCH 1000, SUB 1001, BGE 1010.
REQ-018 IDLE: all outputs 0; next FETCH unconditionally.
REQ-019 FETCH: mem_req, addr_sel=0, alu PC+4 (a=01, b=10, ADD); ir_write and pc_write only when mem_ready; holds in FETCH while mem_ready=0.
REQ-020 DECODE: a=10, b=01, ADD, target_write; next by opcode: 0110011 EXEC_R, 0010011 EXEC_I, 0000011/0100011 MEM_ADDR, 1100011 BRANCH, 1101111 JAL, 0110111 LUI_WB, else HALT.
REQ-021 EXEC_R: a=00, b=00; funct3 000 -> ADD (funct7b5=0) or SUB (=1), 110 OR, 111 AND, other -> HALT; next WB_ALU.
REQ-022 EXEC_I: a=00, b=01; funct3 000 ADDI, 110 OR, 111 AND, other -> HALT; next WB_ALU.
REQ-023 WB_ALU: reg_write, result_src=00; next FETCH.
REQ-024 MEM_ADDR: a=00, b=01, LOAD (load) or STORE (store); funct3 != 010 -> HALT; next MEM_RD or MEM_WR.
REQ-025 MEM_RD: mem_req, addr_sel=1; waits for mem_ready, then MEM_WB. MEM_WB: reg_write, result_src=01; next FETCH.
REQ-026 MEM_WR: mem_req, mem_we, addr_sel=1; waits for mem_ready, then FETCH.
REQ-027 BRANCH: a=00, b=00, funct3 000 BRANCH, 101 BGE, other -> HALT; pc_src=1, pc_write=branch_taken; next FETCH.
REQ-028 JAL: reg_write, result_src=10, pc_src=1, pc_write, alu_func JUMP; next FETCH.
REQ-029 LUI_WB: a=00, b=01, LUI, reg_write, result_src=00 path bypass not used (ALU result written via ALU-out same cycle is forbidden; datapath writes ALU result directly when result_src=11); next FETCH.
REQ-030 HALT: halted=1, all other outputs 0; absorbing until reset.
REQ-031 Latency with mem_ready=1: R/I 4, load 5, store 4, branch/JAL/LUI 3 cycles FETCH-to-FETCH; each mem_ready=0 cycle adds one.
REQ-032 retired SHALL increment by 1 on every transition into FETCH from a non-IDLE state, wrap 0xFFFFFFFF -> 0.
REQ-033 Illegal encodings SHALL never assert reg_write, pc_write or mem_req.

Reset
REQ-034 reset high SHALL, at the next clk edge, force state IDLE, retired 0, halted 0, overriding any pending memory wait.
REQ-035 Outputs SHALL be 0 in the cycle after reset, including reset asserted mid-access.

Structure
REQ-036 ALU codes, opcodes, funct3 values and state encoding SHALL reside in shared package ctrl_pkg.
REQ-037 Opcode/funct decode SHALL be sub-module ctrl_decode (combinational: instr -> class, alu_func, illegal).

Verification
REQ-038 Reset then add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXEC_R(func 0000),WB_ALU; retired=1 after 4 cycles.
REQ-039 lw (0x0000A183) with mem_ready low 3 cycles in MEM_RD -> 8 cycles total, reg_write only in MEM_WB, result_src=01.
REQ-040 beq (0x00208463) branch_taken=1 -> pc_write=1, pc_src=1; branch_taken=0 -> pc_write=0; both 3 cycles.
REQ-041 instr=0xFFFFFFFF -> HALT after DECODE, halted=1, no further strobes for 20 cycles; reset -> IDLE.
REQ-042 Reset asserted during MEM_WR wait -> mem_req=0 next cycle, state IDLE, retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared encodings for the multi-cycle control FSM: state encoding,
// decoded instruction classes, ALU operation codes, RISC-V opcode and
// funct3 values, and the datapath mux select codes.
package ctrl_pkg;

    // Controller states; the 4-bit encoding is exported on the debug port.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_LUI_WB   = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    // Instruction classes produced by the opcode decoder.
    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_LUI    = 3'd6,
        CLS_BAD    = 3'd7
    } instr_class_t;

    // ALU operation codes.
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_ADDI   = 4'b0001;
    localparam logic [3:0] ALU_LOAD   = 4'b0010;
    localparam logic [3:0] ALU_STORE  = 4'b0011;
    localparam logic [3:0] ALU_LUI    = 4'b0100;
    localparam logic [3:0] ALU_JUMP   = 4'b0101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_BRANCH = 4'b1000;
    localparam logic [3:0] ALU_SUB    = 4'b1001;
    localparam logic [3:0] ALU_BGE    = 4'b1010;

    // Opcodes.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // funct3 values.
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ALU operand A / operand B / write-back source selects.
    localparam logic [1:0] A_RS1       = 2'b00;
    localparam logic [1:0] A_PC        = 2'b01;
    localparam logic [1:0] A_OLD_PC    = 2'b10;
    localparam logic [1:0] B_RS2       = 2'b00;
    localparam logic [1:0] B_IMM       = 2'b01;
    localparam logic [1:0] B_FOUR      = 2'b10;
    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_PC      = 2'b10;
    localparam logic [1:0] RES_ALU     = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational opcode/funct decoder for the control FSM.
// Ports:
//   instr         in  32  instruction register contents
//   instr_class   out  3  instruction class (instr_class_t encoding)
//   alu_func      out  4  ALU code for the execute step (ADD when illegal)
//   illegal       out  1  opcode or funct3 not supported
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  instr_class,
    output logic [3:0]  alu_func,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7b5    = instr[30];
    // Register and immediate fields are not needed for control decisions.
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // A known opcode with an unsupported funct3 keeps its class so the FSM
    // still walks into the execute step before halting; only unknown
    // opcodes are classed CLS_BAD.
    always_comb begin
        instr_class = CLS_BAD;
        alu_func    = ALU_ADD;
        illegal     = 1'b1;
        case (opcode)
            OP_R: begin
                instr_class = CLS_R;
                case (funct3)
                    F3_ADD: begin alu_func = funct7b5 ? ALU_SUB : ALU_ADD; illegal = 1'b0; end
                    F3_OR:  begin alu_func = ALU_OR;  illegal = 1'b0; end
                    F3_AND: begin alu_func = ALU_AND; illegal = 1'b0; end
                    default: ;
                endcase
            end
            OP_I: begin
                instr_class = CLS_I;
                case (funct3)
                    F3_ADD: begin alu_func = ALU_ADDI; illegal = 1'b0; end
                    F3_OR:  begin alu_func = ALU_OR;   illegal = 1'b0; end
                    F3_AND: begin alu_func = ALU_AND;  illegal = 1'b0; end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                instr_class = CLS_LOAD;
                if (funct3 == F3_LSW) begin alu_func = ALU_LOAD; illegal = 1'b0; end
            end
            OP_STORE: begin
                instr_class = CLS_STORE;
                if (funct3 == F3_LSW) begin alu_func = ALU_STORE; illegal = 1'b0; end
            end
            OP_BRANCH: begin
                instr_class = CLS_BRANCH;
                case (funct3)
                    F3_BEQ: begin alu_func = ALU_BRANCH; illegal = 1'b0; end
                    F3_BGE: begin alu_func = ALU_BGE;    illegal = 1'b0; end
                    default: ;
                endcase
            end
            OP_JAL: begin
                instr_class = CLS_JAL;
                alu_func    = ALU_JUMP;
                illegal     = 1'b0;
            end
            OP_LUI: begin
                instr_class = CLS_LUI;
                alu_func    = ALU_LUI;
                illegal     = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Moore-style control unit for a multi-cycle RV32 subset datapath.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   instr               instruction register contents
//   mem_ready           memory handshake (access completes when high)
//   branch_taken        ALU branch outcome, used in BRANCH only
//   mem_req, mem_we     memory request and write qualifier
//   addr_sel            memory address source (0 PC, 1 ALU-out)
//   ir_write, pc_write, target_write, reg_write   register enables
//   pc_src              next PC source (0 ALU result, 1 target register)
//   alu_a_sel, alu_b_sel, alu_func, result_src    datapath controls
//   halted, state, retired                        status / debug
module mc_control_fsm
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        target_write,
    output logic        reg_write,
    output logic        pc_src,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [3:0]  alu_func,
    output logic [1:0]  result_src,
    output logic        halted,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    state_t      state_q, state_d;
    logic [31:0] retired_q;
    logic [2:0]  dec_class;
    logic [3:0]  dec_alu_func;
    logic        dec_illegal;

    ctrl_decode u_decode (
        .instr       (instr),
        .instr_class (dec_class),
        .alu_func    (dec_alu_func),
        .illegal     (dec_illegal)
    );

    // Reset wins over any pending memory wait. An instruction retires when
    // we re-enter FETCH from any state other than IDLE or FETCH itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_d == S_FETCH && state_q != S_IDLE && state_q != S_FETCH)
                retired_q <= retired_q + 32'd1;
        end
    end

    // Next-state and output decode. Illegal encodings branch to HALT before
    // any register write, PC write or memory request is issued.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        target_write = 1'b0;
        reg_write    = 1'b0;
        pc_src       = 1'b0;
        alu_a_sel    = A_RS1;
        alu_b_sel    = B_RS2;
        alu_func     = ALU_ADD;
        result_src   = RES_ALU_OUT;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_a_sel = A_PC;
                alu_b_sel = B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_a_sel    = A_OLD_PC;
                alu_b_sel    = B_IMM;
                target_write = 1'b1;
                case (dec_class)
                    CLS_R:                state_d = S_EXEC_R;
                    CLS_I:                state_d = S_EXEC_I;
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM_ADDR;
                    CLS_BRANCH:           state_d = S_BRANCH;
                    CLS_JAL:              state_d = S_JAL;
                    CLS_LUI:              state_d = S_LUI_WB;
                    default:              state_d = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_func = dec_alu_func;
                state_d  = dec_illegal ? S_HALT : S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_b_sel = B_IMM;
                alu_func  = dec_alu_func;
                state_d   = dec_illegal ? S_HALT : S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_b_sel = B_IMM;
                alu_func  = dec_alu_func;
                if (dec_illegal)
                    state_d = S_HALT;
                else
                    state_d = (dec_class == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_func = dec_alu_func;
                if (dec_illegal) begin
                    state_d = S_HALT;
                end else begin
                    pc_src   = 1'b1;
                    pc_write = branch_taken;
                    state_d  = S_FETCH;
                end
            end
            S_JAL: begin
                reg_write  = 1'b1;
                result_src = RES_PC;
                pc_src     = 1'b1;
                pc_write   = 1'b1;
                alu_func   = ALU_JUMP;
                state_d    = S_FETCH;
            end
            S_LUI_WB: begin
                // The ALU result goes straight to the register file, so the
                // write-back source is the live ALU output, not ALU-out.
                alu_b_sel  = B_IMM;
                alu_func   = dec_alu_func;
                reg_write  = 1'b1;
                result_src = RES_ALU;
                state_d    = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    assign halted  = (state_q == S_HALT);
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// Randomized bench for mc_control_fsm. The stimulus process walks each
// instruction through its expected sequence of steps and queues the
// expected outputs for every cycle; a monitor on the falling edge pops and
// compares them against the DUT.
module tb_mc_control_fsm;
    import ctrl_pkg::*;

    typedef struct packed {
        logic [3:0]  st;
        logic        mem_req;
        logic        mem_we;
        logic        addr_sel;
        logic        ir_write;
        logic        pc_write;
        logic        target_write;
        logic        reg_write;
        logic        pc_src;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [3:0]  func;
        logic [1:0]  res;
        logic        halted;
        logic [31:0] retired;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic        target_write, reg_write, pc_src, halted;
    logic [1:0]  alu_a_sel, alu_b_sel, result_src;
    logic [3:0]  alu_func, state;
    logic [31:0] retired;

    exp_t        exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_passed = 0;
    logic [31:0] rmodel = 32'd0;
    int          halt_len = 20;
    logic [2:0]  f3s [5] = '{3'b000, 3'b010, 3'b101, 3'b110, 3'b111};

    exp_t        mon_exp, mon_act;
    string       mon_nm;

    mc_control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .target_write (target_write),
        .reg_write    (reg_write),
        .pc_src       (pc_src),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_func     (alu_func),
        .result_src   (result_src),
        .halted       (halted),
        .state        (state),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_act.st           = state;
            mon_act.mem_req      = mem_req;
            mon_act.mem_we       = mem_we;
            mon_act.addr_sel     = addr_sel;
            mon_act.ir_write     = ir_write;
            mon_act.pc_write     = pc_write;
            mon_act.target_write = target_write;
            mon_act.reg_write    = reg_write;
            mon_act.pc_src       = pc_src;
            mon_act.a_sel        = alu_a_sel;
            mon_act.b_sel        = alu_b_sel;
            mon_act.func         = alu_func;
            mon_act.res          = result_src;
            mon_act.halted       = halted;
            mon_act.retired      = retired;
            n_checks++;
            if (mon_act === mon_exp)
                n_passed++;
            else
                $display("[TB] FAIL %s at %0t: actual %h required %h (state %0d vs %0d, retired %0d vs %0d)",
                         mon_nm, $time, mon_act, mon_exp, mon_act.st, mon_exp.st,
                         mon_act.retired, mon_exp.retired);
        end
    end

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e         = '0;
        e.st      = st;
        e.retired = rmodel;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input exp_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One cycle whose outputs do not depend on the handshake inputs.
    task automatic apply_stimulus(input exp_t e, input string nm);
        mem_ready    = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        push(e, nm);
        tick();
    endtask

    // A state held until mem_ready; forced >= 0 gives that many stall cycles.
    task automatic wait_state(input exp_t base, input bit is_fetch, input int forced, input string nm);
        exp_t e;
        bit   mr;
        for (int k = 0; k < 8; k++) begin
            if (forced >= 0) mr = (k >= forced);
            else             mr = (k >= 3) || ($urandom_range(0, 2) != 0);
            mem_ready    = mr;
            branch_taken = 1'($urandom_range(0, 1));
            e = base;
            if (is_fetch) begin
                e.ir_write = mr;
                e.pc_write = mr;
            end
            push(e, nm);
            tick();
            if (mr) break;
        end
    endtask

    // Reset from the current state: that cycle still shows 'cur', the next is IDLE.
    task automatic reset_from(input exp_t cur, input string nm);
        reset = 1'b1;
        apply_stimulus(cur, nm);
        reset  = 1'b0;
        rmodel = 32'd0;
        apply_stimulus(blank(S_IDLE), "idle_after_reset");
    endtask

    task automatic halt_tail();
        exp_t e;
        for (int k = 0; k < halt_len; k++) begin
            e = blank(S_HALT);
            e.halted = 1'b1;
            instr = $urandom;
            apply_stimulus(e, "halt_quiet");
        end
        e = blank(S_HALT);
        e.halted = 1'b1;
        reset_from(e, "halt_reset_cycle");
    endtask

    // Reference: one instruction from FETCH until the next FETCH (or HALT/reset).
    // bt < 0 randomizes branch_taken; abort_wr resets during the store wait.
    task automatic run_instr(input logic [31:0] ins, input int fetch_w, input int mem_w,
                             input int bt, input bit abort_wr);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        bit         bad;
        bit         retire;
        bit         bt_v;
        op     = ins[6:0];
        f3     = ins[14:12];
        bad    = 1'b0;
        retire = 1'b1;
        instr  = ins;

        e = blank(S_FETCH);
        e.mem_req = 1'b1; e.a_sel = 2'b01; e.b_sel = 2'b10;
        wait_state(e, 1'b1, fetch_w, "fetch");

        e = blank(S_DECODE);
        e.a_sel = 2'b10; e.b_sel = 2'b01; e.target_write = 1'b1;
        apply_stimulus(e, "decode");

        if (op == 7'b0110011 || op == 7'b0010011) begin
            e = blank(op == 7'b0110011 ? S_EXEC_R : S_EXEC_I);
            if (op == 7'b0010011) e.b_sel = 2'b01;
            if (f3 == 3'b000)      e.func = (op == 7'b0010011) ? 4'b0001 : (ins[30] ? 4'b1001 : 4'b0000);
            else if (f3 == 3'b110) e.func = 4'b0110;
            else if (f3 == 3'b111) e.func = 4'b0111;
            else                   bad = 1'b1;
            apply_stimulus(e, op == 7'b0110011 ? "exec_r" : "exec_i");
            if (!bad) begin
                e = blank(S_WB_ALU);
                e.reg_write = 1'b1;
                apply_stimulus(e, "wb_alu");
            end
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            e = blank(S_MEM_ADDR);
            e.b_sel = 2'b01;
            if (f3 == 3'b010) e.func = (op == 7'b0000011) ? 4'b0010 : 4'b0011;
            else              bad = 1'b1;
            apply_stimulus(e, "mem_addr");
            if (!bad && op == 7'b0000011) begin
                e = blank(S_MEM_RD);
                e.mem_req = 1'b1; e.addr_sel = 1'b1;
                wait_state(e, 1'b0, mem_w, "mem_rd");
                e = blank(S_MEM_WB);
                e.reg_write = 1'b1; e.res = 2'b01;
                apply_stimulus(e, "mem_wb");
            end else if (!bad) begin
                e = blank(S_MEM_WR);
                e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 1'b1;
                if (abort_wr) begin
                    mem_ready    = 1'b0;
                    reset        = 1'b1;
                    branch_taken = 1'b0;
                    push(e, "mem_wr_reset_cycle");
                    tick();
                    reset  = 1'b0;
                    rmodel = 32'd0;
                    apply_stimulus(blank(S_IDLE), "idle_after_wr_reset");
                    retire = 1'b0;
                end else begin
                    wait_state(e, 1'b0, mem_w, "mem_wr");
                end
            end
        end else if (op == 7'b1100011) begin
            if (bt < 0) bt_v = 1'($urandom_range(0, 1));
            else        bt_v = (bt != 0);
            e = blank(S_BRANCH);
            if (f3 == 3'b000)      e.func = 4'b1000;
            else if (f3 == 3'b101) e.func = 4'b1010;
            else                   bad = 1'b1;
            if (!bad) begin
                e.pc_src   = 1'b1;
                e.pc_write = bt_v;
            end
            mem_ready    = 1'($urandom_range(0, 1));
            branch_taken = bt_v;
            push(e, "branch");
            tick();
        end else if (op == 7'b1101111) begin
            e = blank(S_JAL);
            e.reg_write = 1'b1; e.res = 2'b10; e.pc_src = 1'b1;
            e.pc_write  = 1'b1; e.func = 4'b0101;
            apply_stimulus(e, "jal");
        end else if (op == 7'b0110111) begin
            e = blank(S_LUI_WB);
            e.b_sel = 2'b01; e.func = 4'b0100; e.reg_write = 1'b1; e.res = 2'b11;
            apply_stimulus(e, "lui_wb");
        end else begin
            bad = 1'b1;
        end

        if (bad) begin
            halt_tail();
            retire = 1'b0;
        end
        if (retire) rmodel = rmodel + 32'd1;
    endtask

    initial begin
        reset        = 1'b1;
        instr        = 32'd0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        tick();
        apply_stimulus(blank(S_IDLE), "reset_idle");
        reset = 1'b0;
        apply_stimulus(blank(S_IDLE), "idle_first");

        run_instr(32'h002081B3, 0, -1, -1, 1'b0);  // add x3,x1,x2
        run_instr(32'h0000A183, 0,  3, -1, 1'b0);  // lw, three stalls in MEM_RD
        run_instr(32'h00208463, 0, -1,  1, 1'b0);  // beq taken
        run_instr(32'h00208463, 0, -1,  0, 1'b0);  // beq not taken
        run_instr(32'h0020D463, 2, -1,  1, 1'b0);  // bge, fetch stalls
        run_instr(32'h402081B3, 0, -1, -1, 1'b0);  // sub
        run_instr(32'h0020E1B3, 0, -1, -1, 1'b0);  // or
        run_instr(32'h0020F1B3, 0, -1, -1, 1'b0);  // and
        run_instr(32'h00500093, 0, -1, -1, 1'b0);  // addi
        run_instr(32'h123450B7, 0, -1, -1, 1'b0);  // lui
        run_instr(32'h008000EF, 0, -1, -1, 1'b0);  // jal
        run_instr(32'h0020A023, 0,  2, -1, 1'b0);  // sw with stalls
        run_instr(32'h0020A023, 0,  1, -1, 1'b1);  // sw, reset during wait
        run_instr(32'h002081B3, 0, -1, -1, 1'b0);  // retired restarts from 0
        run_instr(32'hFFFFFFFF, 0, -1, -1, 1'b0);  // illegal opcode
        halt_len = 4;
        run_instr(32'h002091B3, 0, -1, -1, 1'b0);  // R-type bad funct3
        run_instr(32'h0000B183, 0, -1, -1, 1'b0);  // load bad funct3
        run_instr(32'h00209463, 0, -1,  1, 1'b0);  // branch bad funct3

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ins;
            int          pick;
            ins  = $urandom;
            pick = $urandom_range(0, 7);
            case (pick)
                0: ins[6:0] = 7'b0110011;
                1: ins[6:0] = 7'b0010011;
                2: ins[6:0] = 7'b0000011;
                3: ins[6:0] = 7'b0100011;
                4: ins[6:0] = 7'b1100011;
                5: ins[6:0] = 7'b1101111;
                6: ins[6:0] = 7'b0110111;
                default: ;
            endcase
            if ($urandom_range(0, 4) != 0) ins[14:12] = f3s[$urandom_range(0, 4)];
            halt_len = $urandom_range(2, 5);
            run_instr(ins, -1, -1, -1, (ins[6:0] == 7'b0100011) && ($urandom_range(0, 9) == 0));
        end

        tick();
        tick();
        n_checks++;
        if (exp_q.size() == 0)
            n_passed++;
        else
            $display("[TB] FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
